// File: rtl/vram_fill_arbiter.sv
// Write-port arbiter for the VGA frame RAM: the CPU window always owns port A,
// and a linear fill engine writes one colour into the cycles the CPU leaves free.
// Ports: clk/rst (sync, active high); cpu_* bus path (cpu_dout mirrors vram_dout);
//   fill_* engine control/status; vram_* port-A drive (vram_dout is 1-cycle synchronous read data).
module vram_fill_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 307200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W:0]   fill_count,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  input  logic [DATA_W-1:0] vram_dout
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   rem;
  logic [DATA_W-1:0] fill_c;

  logic [ADDR_W:0]   base_ext;
  logic [ADDR_W:0]   avail;
  logic [ADDR_W:0]   eff_len;
  logic              load;
  logic              grant;

  // Clamp the request so the fill never runs past the last pixel; a base at or
  // beyond the end of the frame yields an empty fill.
  always_comb begin
    base_ext = {1'b0, fill_base};
    avail    = (base_ext < DEPTH_W) ? (DEPTH_W - base_ext) : '0;
    eff_len  = (fill_len < avail) ? fill_len : avail;
  end

  assign load  = (state == IDLE) && fill_start;
  // The fill only gets the port when the CPU is idle; reset also suppresses it
  // so the port follows the CPU alone while rst is held.
  assign grant = (state == FILL) && !cpu_req && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      rem        <= '0;
      fill_c     <= '0;
      fill_count <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        cur_addr   <= fill_base;
        fill_c     <= fill_color;
        rem        <= eff_len;
        fill_count <= '0;
      end else if (grant) begin
        // A granted write always completes, even alongside an abort.
        cur_addr   <= cur_addr + ADDR_W'(1);
        rem        <= rem - (ADDR_W + 1)'(1);
        fill_count <= fill_count + (ADDR_W + 1)'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nx = (eff_len != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        if (fill_abort) begin
          state_nx = IDLE;
        end else if (grant && (rem == (ADDR_W + 1)'(1))) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Port-A mux: CPU has absolute priority, fill uses granted cycles only.
  always_comb begin
    vram_we   = 1'b0;
    vram_addr = '0;
    vram_din  = '0;
    if (cpu_req) begin
      vram_we   = cpu_we;
      vram_addr = cpu_addr;
      vram_din  = cpu_din;
    end else if (grant) begin
      vram_we   = 1'b1;
      vram_addr = cur_addr;
      vram_din  = fill_c;
    end
  end

  assign fill_busy = (state != IDLE);
  // An abort landing on the DONE cycle cancels the completion pulse.
  assign fill_done = (state == DONE) && !fill_abort && !rst;
  assign cpu_dout  = vram_dout;

endmodule

// File: tb/tb_vram_fill_arbiter.sv
module tb_vram_fill_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 307200;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              fill_start;
  logic              fill_abort;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W:0]   fill_len;
  logic [DATA_W-1:0] fill_color;
  logic              fill_busy;
  logic              fill_done;
  logic [ADDR_W:0]   fill_count;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_din;
  logic [DATA_W-1:0] vram_dout;

  vram_fill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .fill_start(fill_start), .fill_abort(fill_abort), .fill_base(fill_base), .fill_len(fill_len),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done), .fill_count(fill_count),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din), .vram_dout(vram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame RAM model: synchronous read-before-write, plus per-address write counts.
  logic [DATA_W-1:0] mem  [0:(1<<ADDR_W)-1];
  int                wcnt [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    vram_dout <= mem[vram_addr];
    if (vram_we) begin
      mem[vram_addr]  <= vram_din;
      wcnt[vram_addr] <= wcnt[vram_addr] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a fill is a list of pixel addresses, handed out one per
  // CPU-free cycle; the completion pulse follows the last one.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  pend[$];
  int  m_phase = 0;  // 0 idle, 1 filling, 2 completion cycle
  int  m_count = 0;
  logic [DATA_W-1:0] m_color = '0;

  task automatic model();
    int b, l, avail, n;
    wr_t w;
    if (cpu_req) begin
      if (cpu_we) begin
        w.a = cpu_addr; w.d = cpu_din;
        exp_wr.push_back(w);
      end
    end else if (!rst && m_phase == 1 && pend.size() > 0) begin
      w.a = ADDR_W'(pend.pop_front()); w.d = m_color;
      exp_wr.push_back(w);
      m_count++;
    end
    if (!rst && m_phase == 2 && !fill_abort) exp_done.push_back(cyc);

    if (rst) begin
      m_phase = 0; pend.delete(); m_count = 0;
    end else begin
      case (m_phase)
        0: if (fill_start) begin
          b = int'(fill_base);
          l = int'(fill_len);
          avail = (b < DEPTH) ? DEPTH - b : 0;
          n = (l < avail) ? l : avail;
          pend.delete();
          for (int i = 0; i < n; i++) pend.push_back(b + i);
          m_color = fill_color;
          m_count = 0;
          m_phase = (n > 0) ? 1 : 2;
        end
        1: if (fill_abort) begin
          m_phase = 0; pend.delete();
        end else if (pend.size() == 0) begin
          m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One cycle: model the cycle whose inputs are now applied, then advance.
  task automatic step();
    model();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes expectations whenever the DUT presents a write or pulse.
  int  last_done = -1;
  wr_t mon_e;
  always @(negedge clk) begin
    if (vram_we) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none (cycle %0d)", vram_addr, vram_din, cyc);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", vram_addr, mon_e.a);
        chk("wr_data", vram_din, mon_e.d);
      end
    end
    if (fill_done) begin
      last_done = cyc;
      if (exp_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  int s;  // cycle in which the current start was presented (edge 0 ends it)

  task automatic start_fill(int base, int len, int color);
    fill_base  = ADDR_W'(base);
    fill_len   = (ADDR_W + 1)'(len);
    fill_color = DATA_W'(color);
    fill_start = 1'b1;
    last_done  = -1;
    s = cyc;
    step();
    fill_start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (fill_busy && n < budget) begin
      step();
      n++;
    end
    if (fill_busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
    end
  endtask

  int snap [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    fill_start = 0; fill_abort = 0; fill_base = '0; fill_len = '0; fill_color = '0;
    step();
    // Reset: CPU writes still pass straight through.
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'd123; cpu_din = 12'hABC;
    #1 chk("rst_vram_we", vram_we, 1);
    step();
    cpu_req = 0; cpu_we = 0; rst = 1'b0;
    #1;
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_count", fill_count, 0);
    chk("rst_vram_we_idle", vram_we, 0);
    step();

    // Basic fill.
    start_fill(100, 4, 12'hF00);
    wait_idle(50);
    chk("basic_done_rel", last_done - s, 5);
    chk("basic_count", fill_count, 4);

    // Interleaving with CPU write then read.
    for (int i = 0; i < 8; i++) snap[i] = wcnt[i];
    start_fill(0, 8, 12'h00F);
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'd5000; cpu_din = 12'h0F0;
    #1;
    chk("cpu_pass_addr", vram_addr, 5000);
    chk("cpu_pass_data", vram_din, 12'h0F0);
    step();
    cpu_we = 0;
    step();
    cpu_req = 0;
    #1 chk("cpu_read", cpu_dout, 12'h0F0);
    wait_idle(50);
    chk("inter_done_rel", last_done - s, 11);
    chk("inter_count", fill_count, 8);
    step();
    for (int i = 0; i < 8; i++) chk($sformatf("inter_once_%0d", i), wcnt[i] - snap[i], 1);

    // Clamp at the end of the frame.
    start_fill(307198, 10, 12'h0A5);
    wait_idle(50);
    chk("clamp_done_rel", last_done - s, 3);
    chk("clamp_count", fill_count, 2);
    start_fill(307200, 5, 12'h5A5);
    wait_idle(50);
    chk("empty_done_rel", last_done - s, 1);
    chk("empty_count", fill_count, 0);

    // Abort in cycle 10, with an ignored start in cycle 5.
    start_fill(1000, 100, 12'h123);
    for (int r = 1; r <= 9; r++) begin
      fill_start = (r == 5);
      if (r == 5) begin fill_base = 19'd50; fill_len = 20'd3; end
      step();
    end
    fill_start = 0;
    fill_abort = 1;
    step();
    fill_abort = 0;
    chk("abort_busy", fill_busy, 0);
    chk("abort_count", fill_count, 10);
    chk("abort_count_model", fill_count, m_count);
    chk("abort_no_done", last_done, -1);
    start_fill(2000, 3, 12'h321);
    wait_idle(50);
    chk("restart_done_rel", last_done - s, 4);
    chk("restart_count", fill_count, 3);

    // Reset in cycle 20 of a long fill.
    start_fill(10000, 1000, 12'h777);
    repeat (19) step();
    rst = 1;
    step();
    rst = 0;
    chk("rstmid_busy", fill_busy, 0);
    chk("rstmid_count", fill_count, 0);
    repeat (5) step();

    // Randomised fills with CPU traffic, stray starts and rare aborts.
    for (int it = 0; it < 25; it++) begin
      int b, l;
      b = ($urandom_range(0, 3) == 0) ? DEPTH - int'($urandom_range(0, 20)) : int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(0, 40));
      start_fill(b, l, int'($urandom_range(0, 4095)));
      for (int n = 0; n < 400 && fill_busy; n++) begin
        cpu_req    = ($urandom_range(0, 3) == 0);
        cpu_we     = $urandom_range(0, 1) == 1;
        cpu_addr   = ADDR_W'($urandom);
        cpu_din    = DATA_W'($urandom);
        fill_abort = ($urandom_range(0, 99) == 0);
        fill_start = ($urandom_range(0, 15) == 0);
        fill_base  = ADDR_W'($urandom_range(0, DEPTH - 1));
        fill_len   = (ADDR_W + 1)'($urandom_range(1, 30));
        step();
      end
      cpu_req = 0; cpu_we = 0; fill_abort = 0; fill_start = 0;
      chk("rand_idle", fill_busy, 0);
      chk("rand_count", fill_count, m_count);
      step();
    end

    repeat (3) step();
    chk("no_missing_writes", exp_wr.size(), 0);
    chk("no_missing_done", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
